mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory between two requesters: the pipelined CPU's fetch stage (I port) and its memory stage (D port). It serialises accesses, drives the memory's address, size, write-data and write-enable pins, returns registered read data with a one-cycle acknowledge pulse, and emulates a configurable memory latency. Data accesses have priority, with a starvation guard that keeps fetch progressing.

## Interface
- `LAT`, default 1: number of BUSY cycles per access (≥1).
- `STARVE_MAX`, default 4: consecutive lost arbitrations after which I wins.
- `CLK  in  1`: clock; all state changes on rising edge.
- `RST  in  1`: reset, asynchronous, active-high.
- `IReq  in  1`: fetch request; held with `IAddr` until `IAck`.
- `IAddr  in  32`: fetch byte address; always a word access.
- `IAck  out  1`: one-cycle pulse; `IData` valid from this cycle on.
- `IData  out  32`: registered fetch data; held until the next I access completes.
- `DReq  in  1`: data request; held with its payload until `DAck`.
- `DAddr  in  32`, `DSize  in  2`, `DWE  in  1`, `DWData  in  32`: data address, size (00 byte, 01 half, 1x word), write flag, store data.
- `DAck  out  1`: one-cycle pulse.
- `DRData  out  32`: registered load data; held until the next D read completes.
- `MAddr  out  32`, `MSize  out  2`, `MWData  out  32`: memory pins, driven from latched request.
- `MWE  out  1`: memory write enable.
- `MRData  in  32`: combinational memory read data.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: `state`, `owner` (I/D), `cnt`, `starve`, plus latched `addr`, `size`, `wdata`, and `we`.
- IDLE with no request: stay. With requests, latch the winner's payload, set `owner`, and load `cnt = LAT-1`, then move to BUSY.
  - For I, latch `size = 2'b10` and `we = 0`.
- Arbitration:
  - D only → D. I only → I.
  - Both requesting and `starve < STARVE_MAX` → D, and `starve` increments, saturating at `STARVE_MAX`.
  - Both requesting and `starve == STARVE_MAX` → I.
  - Any I grant clears `starve`.
- BUSY: `MAddr`, `MSize`, and `MWData` come from latched values. `cnt` decrements each cycle.
  - When `cnt == 0`: `MWE = we` (combinational, final BUSY cycle only). Read data `MRData` is captured into `IData` or `DRData` per `owner` on that edge. A write does not update `DRData`.
  - Then go to DONE.
- DONE: the owner's Ack is high for exactly this cycle. No arbitration. Next state is IDLE.
- Request payload changes after the grant edge are ignored. A requester that keeps Req high into IDLE after its Ack is issuing a new request.
- Outside BUSY: `MAddr = 0`, `MSize = 0`, `MWData = 0`, `MWE = 0`.

## Timing
- Request seen in IDLE at cycle 0:
  - BUSY occupies cycles 1..LAT.
  - The memory write lands on the rising edge ending cycle LAT.
  - Ack is high in cycle LAT+1.
  - IDLE returns in cycle LAT+2.
- Throughput is one access per LAT+2 cycles. With LAT=1: Ack in cycle 2, next grant decision in cycle 3.
- Reset values: state IDLE; `owner` I; `cnt` 0; `starve` 0; all latched registers 0; `IAck`, `DAck`, and `MWE` 0; `IData` and `DRData` 0.
- Reset mid-BUSY aborts the access. `MWE` drops immediately, so no partial write occurs after reset asserts. No Ack is issued.
- Reset during DONE cancels the pending Ack.
- A request and its Ack never overlap another requester's access. Exactly one of `IAck`/`DAck` can be high in any cycle.
- `LAT=1`: BUSY lasts one cycle, with `cnt` already 0 on entry.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE, BUSY, DONE);
  - owner encoding;
  - size constants `SZ_BYTE = 2'b00`, `SZ_HALF = 2'b01`, `SZ_WORD = 2'b10`.
- Sub-module `arb_pick`: combinational D-priority pick with starvation override, taking `IReq`, `DReq`, and `starve` and producing the winner.
- Everything else (FSM, counter, latches, read-data registers) lives in `mem_port_arbiter`.
- Intended instantiation is between the CPU stages and `Mem`, with `MAddr` feeding `Mem` `DataAddr`/`InstAddr` and `MRData` from `DataOut`.

## Test plan
- **Single fetch:** LAT=1, `IReq=1`, `IAddr=0x10`, memory word 0xDEADBEEF at 0x10 → `IAck` in cycle 2, `IData=0xDEADBEEF`, `MWE` never high.
- **Word store then load:** `DWE=1`, `DAddr=0x40`, `DSize=10`, `DWData=0x12345678` → `MWE` high only in the BUSY cycle and memory[0x40..0x43] = 78 56 34 12. The following load at 0x40 → `DRData=0x12345678`.
- **Contention and starvation:** STARVE_MAX=2, with `IReq` and `DReq` held high continuously.
  - Required grant order: D, D, I, D, D, I.
  - `IAck` and `DAck` are never high together.
- **Latency:** LAT=3, one fetch → BUSY for 3 cycles, `IAck` in cycle 4. Changing `IAddr` during BUSY does not change `MAddr`.
- **Reset mid-store:** LAT=3, assert `RST` in the second BUSY cycle of a store → `MWE` stays 0, memory unchanged, no `DAck`, all outputs at reset values, IDLE after release.
- **Byte store:** `DSize=00`, `DAddr=0x41`, `DWData=0xAB` → `MSize=00` in BUSY and only byte 0x41 changes.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, access
// owner and access-size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: data port has priority unless fetch has
// lost STARVE_MAX arbitrations in a row.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          IReq,
  input  logic          DReq,
  input  logic [SW-1:0] starve,
  output logic          valid,
  output logic          contended,
  output owner_t        winner
);

  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic starved;

  assign starved   = (starve >= STARVE_TOP);
  assign valid     = IReq | DReq;
  assign contended = IReq & DReq;

  always_comb begin
    winner = OWN_I;
    if (DReq && !(IReq && starved)) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (I) and data (D) accesses onto one memory port, with an
// emulated LAT-cycle access time and registered read data per requester.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// BUSY  | access on the memory pins; cnt counts down to the final cycle
// DONE  | owner's Ack pulse; returns to IDLE without arbitrating
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IAck,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic [31:0] DAddr,
  input  logic [1:0]  DSize,
  input  logic        DWE,
  input  logic [31:0] DWData,
  output logic        DAck,
  output logic [31:0] DRData,
  output logic [31:0] MAddr,
  output logic [1:0]  MSize,
  output logic [31:0] MWData,
  output logic        MWE,
  input  logic [31:0] MRData
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic [31:0]   addr, addr_nxt;
  logic [1:0]    size, size_nxt;
  logic [31:0]   wdata, wdata_nxt;
  logic          we, we_nxt;
  logic [31:0]   idata_nxt, drdata_nxt;

  logic   pick_valid;
  logic   pick_both;
  owner_t pick_owner;
  logic   busy;
  logic   last_busy;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .IReq      (IReq),
    .DReq      (DReq),
    .starve    (starve),
    .valid     (pick_valid),
    .contended (pick_both),
    .winner    (pick_owner)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      owner  <= OWN_I;
      cnt    <= '0;
      starve <= '0;
      addr   <= '0;
      size   <= '0;
      wdata  <= '0;
      we     <= 1'b0;
      IData  <= '0;
      DRData <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
      starve <= starve_nxt;
      addr   <= addr_nxt;
      size   <= size_nxt;
      wdata  <= wdata_nxt;
      we     <= we_nxt;
      IData  <= idata_nxt;
      DRData <= drdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    starve_nxt = starve;
    addr_nxt   = addr;
    size_nxt   = size;
    wdata_nxt  = wdata;
    we_nxt     = we;
    idata_nxt  = IData;
    drdata_nxt = DRData;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_BUSY;
          owner_nxt = pick_owner;
          cnt_nxt   = CNT_LOAD;
          if (pick_owner == OWN_I) begin
            addr_nxt   = IAddr;
            size_nxt   = SZ_WORD;
            wdata_nxt  = '0;
            we_nxt     = 1'b0;
            starve_nxt = '0;
          end else begin
            addr_nxt  = DAddr;
            size_nxt  = DSize;
            wdata_nxt = DWData;
            we_nxt    = DWE;
            // Only a contested loss counts toward fetch starvation.
            if (pick_both && (starve != STARVE_TOP)) begin
              starve_nxt = starve + SW'(1);
            end
          end
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
          if (owner == OWN_I) begin
            idata_nxt = MRData;
          end else if (!we) begin
            drdata_nxt = MRData;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pins are decoded from registered state so reset silences them at once.
  assign busy      = (state == ST_BUSY);
  assign last_busy = busy && (cnt == '0);

  assign MAddr  = busy ? addr  : '0;
  assign MSize  = busy ? size  : '0;
  assign MWData = busy ? wdata : '0;
  assign MWE    = last_busy && we;

  assign IAck = (state == ST_DONE) && (owner == OWN_I);
  assign DAck = (state == ST_DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: LAT=1/STARVE_MAX=2 instance driven from a transaction table plus a
// contention sequence; LAT=3 instance for latency and reset-abort sequences.
module tb_mem_port_arbiter;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    logic        dwe;
    logic [31:0] dwdata;
    logic        exp_i;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    logic [1:0]  exp_msize;
    logic [31:0] exp_mwdata;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic init_mem;

  logic        rst0, ireq0, iack0, dreq0, dwe0, dack0, mwe0;
  logic [31:0] iaddr0, idata0, daddr0, dwdata0, drdata0, maddr0, mwdata0, mrdata0;
  logic [1:0]  dsize0, msize0;

  logic        rst1, ireq1, iack1, dreq1, dwe1, dack1, mwe1;
  logic [31:0] iaddr1, idata1, daddr1, dwdata1, drdata1, maddr1, mwdata1, mrdata1;
  logic [1:0]  dsize1, msize1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] a0, a1;

  vec_t vt [9];
  int   exp_ord [6];
  int   ord [6];
  int   ack_at [6];
  int   n_ack;
  logic dbl;
  int   ack_k, mwe_cnt, busy_cnt, addr_ok, bad_evt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(1), .STARVE_MAX(2)) u0 (
    .CLK(clk), .RST(rst0),
    .IReq(ireq0), .IAddr(iaddr0), .IAck(iack0), .IData(idata0),
    .DReq(dreq0), .DAddr(daddr0), .DSize(dsize0), .DWE(dwe0), .DWData(dwdata0),
    .DAck(dack0), .DRData(drdata0),
    .MAddr(maddr0), .MSize(msize0), .MWData(mwdata0), .MWE(mwe0), .MRData(mrdata0)
  );

  mem_port_arbiter #(.LAT(3)) u1 (
    .CLK(clk), .RST(rst1),
    .IReq(ireq1), .IAddr(iaddr1), .IAck(iack1), .IData(idata1),
    .DReq(dreq1), .DAddr(daddr1), .DSize(dsize1), .DWE(dwe1), .DWData(dwdata1),
    .DAck(dack1), .DRData(drdata1),
    .MAddr(maddr1), .MSize(msize1), .MWData(mwdata1), .MWE(mwe1), .MRData(mrdata1)
  );

  // Little-endian byte memories; reads are combinational from the pins.
  assign a0 = maddr0[7:0];
  assign a1 = maddr1[7:0];
  assign mrdata0 = {mem0[a0 + 8'd3], mem0[a0 + 8'd2], mem0[a0 + 8'd1], mem0[a0]};
  assign mrdata1 = {mem1[a1 + 8'd3], mem1[a1 + 8'd2], mem1[a1 + 8'd1], mem1[a1]};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 8'h00;
        mem1[i] <= 8'h00;
      end
      mem0[8'h10] <= 8'hEF; mem0[8'h11] <= 8'hBE; mem0[8'h12] <= 8'hAD; mem0[8'h13] <= 8'hDE;
      mem1[8'h10] <= 8'hEF; mem1[8'h11] <= 8'hBE; mem1[8'h12] <= 8'hAD; mem1[8'h13] <= 8'hDE;
    end else begin
      if (mwe0) begin
        mem0[a0] <= mwdata0[7:0];
        if (msize0 != 2'b00) mem0[a0 + 8'd1] <= mwdata0[15:8];
        if (msize0[1]) begin
          mem0[a0 + 8'd2] <= mwdata0[23:16];
          mem0[a0 + 8'd3] <= mwdata0[31:24];
        end
      end
      if (mwe1) begin
        mem1[a1] <= mwdata1[7:0];
        if (msize1 != 2'b00) mem1[a1 + 8'd1] <= mwdata1[15:8];
        if (msize1[1]) begin
          mem1[a1 + 8'd2] <= mwdata1[23:16];
          mem1[a1 + 8'd3] <= mwdata1[31:24];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One transaction on u0; expected ack in cycle LAT+1 = 2.
  task automatic run_vec(input int idx, input vec_t v);
    logic        got_i, got_d;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_size;
    int          lat, wcnt;
    lat = 0; wcnt = 0; got_i = 0; got_d = 0;
    b_addr = '0; b_wdata = '0; b_size = '0;
    @(negedge clk);
    ireq0 = v.ireq; iaddr0 = v.iaddr;
    dreq0 = v.dreq; daddr0 = v.daddr; dsize0 = v.dsize; dwe0 = v.dwe; dwdata0 = v.dwdata;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (mwe0) wcnt++;
      if (k == 1) begin
        b_addr = maddr0; b_size = msize0; b_wdata = mwdata0;
      end
      if (iack0 || dack0) begin
        lat = k; got_i = iack0; got_d = dack0;
      end
    end
    ireq0 = 0; dreq0 = 0;
    chk($sformatf("v%0d_ack_cycle", idx), lat, 2);
    chk($sformatf("v%0d_iack", idx), {31'd0, got_i}, {31'd0, v.exp_i});
    chk($sformatf("v%0d_dack", idx), {31'd0, got_d}, {31'd0, ~v.exp_i});
    chk($sformatf("v%0d_rdata", idx), v.exp_i ? idata0 : drdata0, v.exp_rdata);
    chk($sformatf("v%0d_maddr", idx), b_addr, v.exp_maddr);
    chk($sformatf("v%0d_msize", idx), {30'd0, b_size}, {30'd0, v.exp_msize});
    chk($sformatf("v%0d_mwdata", idx), b_wdata, v.exp_mwdata);
    chk($sformatf("v%0d_mwe_cycles", idx), wcnt, (!v.exp_i && v.dwe) ? 1 : 0);
  endtask

  initial begin
    //        ireq dreq iaddr     daddr     sz     we   dwdata        expI rdata         maddr     msz    mwdata
    vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0,  2'b10, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'h10, 2'b10, 32'h0};
    vt[1] = '{1'b0, 1'b1, 32'h0,  32'h40, 2'b10, 1'b1, 32'h12345678, 1'b0, 32'h0,        32'h40, 2'b10, 32'h12345678};
    vt[2] = '{1'b0, 1'b1, 32'h0,  32'h40, 2'b10, 1'b0, 32'h0,        1'b0, 32'h12345678, 32'h40, 2'b10, 32'h0};
    vt[3] = '{1'b0, 1'b1, 32'h0,  32'h41, 2'b00, 1'b1, 32'hAB,       1'b0, 32'h12345678, 32'h41, 2'b00, 32'hAB};
    vt[4] = '{1'b0, 1'b1, 32'h0,  32'h40, 2'b10, 1'b0, 32'h0,        1'b0, 32'h1234AB78, 32'h40, 2'b10, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h40, 32'h0,  2'b00, 1'b0, 32'h0,        1'b1, 32'h1234AB78, 32'h40, 2'b10, 32'h0};
    vt[6] = '{1'b0, 1'b1, 32'h0,  32'h44, 2'b01, 1'b1, 32'hCAFE,     1'b0, 32'h1234AB78, 32'h44, 2'b01, 32'hCAFE};
    vt[7] = '{1'b0, 1'b1, 32'h0,  32'h44, 2'b10, 1'b0, 32'h0,        1'b0, 32'h0000CAFE, 32'h44, 2'b10, 32'h0};
    vt[8] = '{1'b1, 1'b1, 32'h10, 32'h40, 2'b10, 1'b0, 32'h0,        1'b0, 32'h1234AB78, 32'h40, 2'b10, 32'h0};
    exp_ord = '{0, 0, 1, 0, 0, 1};

    rst0 = 1; rst1 = 1; init_mem = 1;
    ireq0 = 0; iaddr0 = 0; dreq0 = 0; daddr0 = 0; dsize0 = 0; dwe0 = 0; dwdata0 = 0;
    ireq1 = 0; iaddr1 = 0; dreq1 = 0; daddr1 = 0; dsize1 = 0; dwe1 = 0; dwdata1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 0;
    chk("rst_acks", {30'd0, iack0, dack0}, 32'd0);
    chk("rst_idata", idata0, 32'd0);
    chk("rst_drdata", drdata0, 32'd0);
    chk("rst_pins", maddr0 | mwdata0 | {30'd0, msize0} | {31'd0, mwe0}, 32'd0);
    rst0 = 0; rst1 = 0;

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    chk("mem_40_43", {mem0[8'h43], mem0[8'h42], mem0[8'h41], mem0[8'h40]}, 32'h1234AB78);
    chk("mem_44_47", {mem0[8'h47], mem0[8'h46], mem0[8'h45], mem0[8'h44]}, 32'h0000CAFE);

    // Contention with STARVE_MAX=2: both held high, fresh starve count.
    @(negedge clk);
    rst0 = 1;
    @(negedge clk);
    rst0 = 0;
    ireq0 = 1; iaddr0 = 32'h10;
    dreq0 = 1; daddr0 = 32'h40; dsize0 = 2'b10; dwe0 = 0; dwdata0 = 0;
    n_ack = 0; dbl = 0;
    for (int k = 1; k <= 60 && n_ack < 6; k++) begin
      @(negedge clk);
      if (iack0 && dack0) dbl = 1;
      if (iack0 || dack0) begin
        ord[n_ack] = iack0 ? 1 : 0;
        ack_at[n_ack] = k;
        n_ack++;
      end
    end
    ireq0 = 0; dreq0 = 0;
    chk("cont_acks", n_ack, 6);
    chk("cont_double_ack", {31'd0, dbl}, 32'd0);
    for (int i = 0; i < n_ack; i++) begin
      chk($sformatf("cont_order%0d", i), ord[i], exp_ord[i]);
      chk($sformatf("cont_at%0d", i), ack_at[i], 2 + 3 * i);
    end
    chk("cont_idata", idata0, 32'hDEADBEEF);
    chk("cont_drdata", drdata0, 32'h1234AB78);

    // LAT=3 fetch; IAddr changes mid-access must not reach the pins.
    @(negedge clk);
    ireq1 = 1; iaddr1 = 32'h10;
    ack_k = 0; mwe_cnt = 0; busy_cnt = 0; addr_ok = 0; bad_evt = 0;
    for (int k = 1; k <= 20 && ack_k == 0; k++) begin
      @(negedge clk);
      if (mwe1) mwe_cnt++;
      if (maddr1 != 0) busy_cnt++;
      if (maddr1 == 32'h10 && msize1 == 2'b10) addr_ok++;
      if (dack1) bad_evt++;
      if (iack1) ack_k = k;
      if (k == 1) iaddr1 = 32'h20;
    end
    ireq1 = 0;
    chk("lat3_ack_cycle", ack_k, 4);
    chk("lat3_busy_cycles", busy_cnt, 3);
    chk("lat3_addr_held", addr_ok, 3);
    chk("lat3_mwe", mwe_cnt, 0);
    chk("lat3_dack", bad_evt, 0);
    chk("lat3_idata", idata1, 32'hDEADBEEF);

    // Reset in the second BUSY cycle of a LAT=3 store.
    @(negedge clk);
    dreq1 = 1; daddr1 = 32'h40; dsize1 = 2'b10; dwe1 = 1; dwdata1 = 32'h55667788;
    @(negedge clk);
    chk("rststore_busy_addr", maddr1, 32'h40);
    @(negedge clk);
    rst1 = 1; dreq1 = 0;
    #1;
    chk("rststore_mwe", {31'd0, mwe1}, 32'd0);
    chk("rststore_acks", {30'd0, iack1, dack1}, 32'd0);
    chk("rststore_idata", idata1, 32'd0);
    chk("rststore_drdata", drdata1, 32'd0);
    chk("rststore_pins", maddr1 | mwdata1 | {30'd0, msize1}, 32'd0);
    bad_evt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst1 = 0;
      if (mwe1 || dack1 || iack1) bad_evt++;
    end
    chk("rststore_no_events", bad_evt, 0);
    chk("rststore_mem", {mem1[8'h43], mem1[8'h42], mem1[8'h41], mem1[8'h40]}, 32'h0);

    // Back in IDLE: a fresh fetch completes with normal latency.
    ireq1 = 1; iaddr1 = 32'h10;
    ack_k = 0;
    for (int k = 1; k <= 20 && ack_k == 0; k++) begin
      @(negedge clk);
      if (iack1) ack_k = k;
    end
    ireq1 = 0;
    chk("postrst_ack_cycle", ack_k, 4);
    chk("postrst_idata", idata1, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
